// File: rtl/cim_cmd_scheduler.sv
// Front-end scheduler for MUL_controller: round-robin compute queue from two
// requesters, plus serialised external load/store issue on the shared command port.
module cim_cmd_scheduler #(
    parameter int FIFO_DEPTH  = 4,
    parameter int LDST_GAP    = 2,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req0_valid,
    input  logic [24:0]                   req0_command,
    output logic                          req0_ready,
    input  logic                          req1_valid,
    input  logic [24:0]                   req1_command,
    output logic                          req1_ready,
    input  logic                          ldst_valid,
    input  logic [6:0]                    ldst_command,
    output logic                          ldst_ready,
    input  logic                          Compute_ready,
    output logic                          Compute_valid,
    output logic [24:0]                   Compute_command,
    output logic                          ExLdSt_valid,
    output logic [6:0]                    ExLdSt_command,
    output logic                          cmp_src,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = 16;

    typedef enum logic [1:0] {ST_IDLE, ST_CMP_ACK, ST_CMP_BUSY, ST_LDST_GAP} state_e;
    typedef enum logic {CLS_COMPUTE, CLS_LDST} cls_e;

    logic [25:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rr_ptr_q, rr_ptr_d;
    state_e        state_q, state_d;
    cls_e          last_q, last_d;
    logic          pend_q, pend_d;
    logic [TW-1:0] cnt_q, cnt_d;

    logic          full, empty, grant0, grant1, push, pop;
    logic          cmp_issue, ldst_issue;
    logic [25:0]   head, push_data;

    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign head      = mem_q[rd_ptr_q];
    assign push      = grant0 | grant1;
    assign push_data = grant1 ? {1'b1, req1_command} : {1'b0, req0_command};

    // Full FIFO refuses both requesters even when a pop happens this cycle.
    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        rr_ptr_d = rr_ptr_q;
        if (rst_n && !full) begin
            if (req0_valid && (!req1_valid || !rr_ptr_q)) begin
                grant0   = 1'b1;
                rr_ptr_d = 1'b1;
            end else if (req1_valid) begin
                grant1   = 1'b1;
                rr_ptr_d = 1'b0;
            end
        end
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // A presented compute (pend_q) keeps priority until the controller takes it.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        cmp_issue  = 1'b0;
        ldst_issue = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty && (pend_q || !ldst_valid || last_q == CLS_LDST)) begin
                    cmp_issue = 1'b1;
                    if (Compute_ready) begin
                        pop     = 1'b1;
                        last_d  = CLS_COMPUTE;
                        pend_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_CMP_ACK;
                    end else begin
                        pend_d  = 1'b1;
                    end
                end else if (ldst_valid) begin
                    ldst_issue = 1'b1;
                    last_d     = CLS_LDST;
                    cnt_d      = TW'(LDST_GAP);
                    state_d    = ST_LDST_GAP;
                end
            end
            ST_CMP_ACK: begin
                if (!Compute_ready) begin
                    state_d = ST_CMP_BUSY;
                end else if (cnt_q >= TW'(ACK_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            ST_CMP_BUSY: begin
                if (Compute_ready) state_d = ST_IDLE;
            end
            ST_LDST_GAP: begin
                // A zero gap still spends one cycle here so ExLdSt never pulses back to back.
                if (cnt_q <= TW'(1)) state_d = ST_IDLE;
                else                 cnt_d   = cnt_q - TW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            last_q   <= CLS_COMPUTE;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            rr_ptr_q <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign req0_ready      = grant0;
    assign req1_ready      = grant1;
    assign Compute_valid   = rst_n & cmp_issue;
    assign Compute_command = empty ? '0 : head[24:0];
    assign cmp_src         = !empty & head[25];
    assign ExLdSt_valid    = rst_n & ldst_issue;
    assign ExLdSt_command  = ExLdSt_valid ? ldst_command : '0;
    assign ldst_ready      = ExLdSt_valid;
    assign fifo_count      = count_q;
    assign busy            = (state_q != ST_IDLE) || !empty;

endmodule

// File: doc/cim_cmd_scheduler.md
Name: cim_cmd_scheduler

Overview:
- Front-end scheduler for MUL_controller.
- Accepts compute commands from two requesters and load/store commands from one requester.
- Queues compute commands in a shared FIFO with round-robin fairness.
- Serialises compute and external load/store issue so the controller's single command port is never double-booked. Its outputs drive MUL_controller's Compute_* and ExLdSt_* inputs directly.

Parameters:
- FIFO_DEPTH, 4, compute queue entries; power of two, 2..16.
- LDST_GAP, 2, idle cycles enforced after each ExLdSt issue (ExLdSt has no ready).
- ACK_TIMEOUT, 8, cycles to wait for Compute_ready to drop after a transfer before treating the op as complete.

Ports:
- clk in 1: single clock, rising edge.
- rst_n in 1: synchronous, active-low reset.
- req0_valid in 1: requester 0 compute command valid.
- req0_command in 25: requester 0 compute command.
- req0_ready out 1: requester 0 accepted this cycle.
- req1_valid in 1: requester 1 compute command valid.
- req1_command in 25: requester 1 compute command.
- req1_ready out 1: requester 1 accepted this cycle.
- ldst_valid in 1: load/store request valid.
- ldst_command in 7: load/store command.
- ldst_ready out 1: load/store accepted and issued this cycle.
- Compute_ready in 1: from MUL_controller; high = idle/accepting.
- Compute_valid out 1: to MUL_controller.
- Compute_command out 25: FIFO head.
- ExLdSt_valid out 1: one-cycle issue pulse.
- ExLdSt_command out 7: issued load/store command.
- cmp_src out 1: requester id of the FIFO head.
- fifo_count out log2(FIFO_DEPTH)+1: FIFO occupancy.
- busy out 1: state != IDLE or FIFO non-empty.

Behaviour:
- Reset: on a rising edge with rst_n=0, clear FIFO, state=IDLE, rr_ptr=0, last_class=COMPUTE, counters=0. All outputs are 0 from the following cycle. Reset mid-operation discards queued and in-flight commands with no completion wait.
- Enqueue arbiter (independent of the issue FSM):
  - When fifo_count < FIFO_DEPTH, grant one valid requester.
  - If both are valid, grant the one rr_ptr points to; rr_ptr then moves to the other.
  - If one is valid, grant it and set rr_ptr to the other.
  - reqN_ready=1 only for the granted requester (combinational). Transfer = valid & ready; push {id, command}.
  - Full FIFO gives both ready=0 even if a pop occurs in the same cycle (no pass-through). Push and pop in the same cycle are allowed when not full; count is unchanged.
- Issue FSM states: IDLE, CMP_ACK, CMP_BUSY, LDST_GAP.
- IDLE:
  - Candidates are cmp_ok = FIFO non-empty and ld_ok = ldst_valid.
  - If both are candidates, pick the class opposite last_class. Otherwise pick the single candidate.
  - Compute pick: Compute_valid=1, Compute_command=head. On Compute_ready=1, pop, set last_class=COMPUTE, go to CMP_ACK. If Compute_ready=0, hold valid and command stable and stay in IDLE; a new ldst_valid cannot preempt a presented compute.
  - Load/store pick: ExLdSt_valid=1, ExLdSt_command=ldst_command, ldst_ready=1 for exactly this cycle; set last_class=LDST, load gap counter=LDST_GAP, go to LDST_GAP.
- CMP_ACK:
  - Compute_valid=0; count cycles.
  - Compute_ready=0 goes to CMP_BUSY.
  - ACK_TIMEOUT cycles elapsed with Compute_ready still 1 goes to IDLE (zero-latency op).
- CMP_BUSY: wait for Compute_ready=1, then go to IDLE. There is no timeout.
- LDST_GAP: decrement the counter each cycle; at 0 go to IDLE. With LDST_GAP=0, return directly to IDLE the next cycle.
- ExLdSt_valid is never high in two consecutive cycles. Compute_valid and ExLdSt_valid are never high together.
- ldst_ready is 0 outside IDLE. req*_ready is unaffected by FSM state.
- cmp_src and Compute_command are meaningful only while FIFO is non-empty; they are 0 when empty.

Test Plan:
- Reset then idle: after rst_n=0 for 2 cycles, all outputs=0, fifo_count=0, busy=0.
- Round-robin enqueue: req0 and req1 both valid with 0x0000001 and 0x0000002, controller stalled (Compute_ready=0). Order must be 0x0000001 (src 0), then 0x0000002 (src 1), alternating. After 4 accepts fifo_count=4, both ready=0.
- Compute handshake: queue 0x1ABCDEF, Compute_ready=1. Compute_valid is high 1 cycle and pops. Then drop Compute_ready for 5 cycles → CMP_ACK→CMP_BUSY; no new issue until Compute_ready rises, then next head issues 1 cycle later.
- Class alternation: FIFO holds 2 commands and ldst_valid is held with 0x35. Issue order must be LDST, COMPUTE, LDST, COMPUTE. Each ExLdSt pulse is followed by ≥2 idle cycles (LDST_GAP=2).
- Ack timeout: Compute_ready held at 1 permanently. Successive compute issues must be spaced exactly ACK_TIMEOUT+1 cycles apart.
- Reset mid-op: assert rst_n=0 in CMP_BUSY with 3 entries queued. Next cycle fifo_count=0, Compute_valid=0, and the first command after reset is taken from req0.
